// File: rtl/mcac_sched_pkg.sv
// Shared types and default sizing for the multi-channel codec frame scheduler.
// Build option MCAC_SCHED_WDOG_EN enables the per-channel watchdog in mcac_chan_sched.
package mcac_sched_pkg;

   localparam int NCH_DEF         = 32;
   localparam int CHW_DEF         = 5;
   localparam int WDOG_CYCLES_DEF = 1023;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/mcac_ffs.sv
// Find-first-set over a channel mask: lowest set bit index plus an all-clear flag.
// Purely combinational, zero latency; no flow control.
module mcac_ffs #(
   parameter int NCH = 32,
   parameter int CHW = 5
) (
   input  logic [NCH-1:0] vec,
   output logic [CHW-1:0] idx,
   output logic           none
);

   // Scan downwards so the lowest set bit is the last one to assign.
   always_comb begin
      idx  = '0;
      none = 1'b1;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx  = CHW'(i);
            none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mcac_chan_sched.sv
// Per-frame scheduler issuing one start/done job per enabled channel, ascending, to the shared ADPCM engine.
// fs to res_start is 1 cycle; res_done to next res_start is 1 cycle; waits on res_done (watchdog via MCAC_SCHED_WDOG_EN).
module mcac_chan_sched
   import mcac_sched_pkg::*;
#(
   parameter int NCH         = NCH_DEF,
   parameter int CHW         = CHW_DEF,
   parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           fs,
   input  logic [NCH-1:0] chan_en,
   input  logic           ovr_clr,
   input  logic           res_done,
   output logic           res_start,
   output logic [CHW-1:0] res_chan,
   output logic           busy,
   output logic           frame_done,
   output logic [CHW:0]   done_cnt,
   output logic           overrun,
   output logic           wdog_err
);

   if (NCH > (1 << CHW) || WDOG_CYCLES < 2) begin : g_bad_param
      $error("mcac_chan_sched: inconsistent NCH/CHW/WDOG_CYCLES");
   end

   state_t         state_q, state_d;
   logic [NCH-1:0] en_q, en_d, en_clr, ffs_vec;
   logic [CHW-1:0] ffs_idx, res_chan_d;
   logic           ffs_none;
   logic           ch_end, wdog_hit;
   logic           res_start_d, busy_d, frame_done_d, overrun_d, wdog_err_d;
   logic [CHW:0]   done_cnt_d;

   // Remaining mask once the channel in flight retires.
   assign en_clr  = en_q & ~({{(NCH-1){1'b0}}, 1'b1} << res_chan);
   assign ffs_vec = (state_q == IDLE) ? chan_en : en_clr;

   mcac_ffs #(.NCH(NCH), .CHW(CHW)) u_ffs (
      .vec  (ffs_vec),
      .idx  (ffs_idx),
      .none (ffs_none)
   );

`ifdef MCAC_SCHED_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wdog_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                wdog_cnt <= '0;
      else if (state_q != WAIT)  wdog_cnt <= '0;
      else                       wdog_cnt <= wdog_cnt + 1'b1;
   end

   // A real completion in the same cycle takes priority over the abort.
   assign wdog_hit = (state_q == WAIT) && !res_done && (wdog_cnt == WW'(WDOG_CYCLES - 1));
`else
   assign wdog_hit = 1'b0;
`endif

   assign ch_end = (state_q == WAIT) && (res_done || wdog_hit);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fs && !ffs_none) state_d = START;
         START:   state_d = WAIT;
         WAIT:    if (ch_end) state_d = ffs_none ? IDLE : START;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      en_d         = en_q;
      res_chan_d   = res_chan;
      done_cnt_d   = done_cnt;
      busy_d       = busy;
      frame_done_d = 1'b0;
      wdog_err_d   = wdog_err | wdog_hit;
      res_start_d  = (state_d == START);
      case (state_q)
         IDLE: begin
            if (fs) begin
               en_d       = chan_en;
               done_cnt_d = '0;
               if (ffs_none) begin
                  frame_done_d = 1'b1;
               end else begin
                  res_chan_d = ffs_idx;
                  busy_d     = 1'b1;
               end
            end
         end
         WAIT: begin
            if (ch_end) begin
               en_d = en_clr;
               if (res_done) done_cnt_d = done_cnt + 1'b1;
               if (ffs_none) begin
                  frame_done_d = 1'b1;
                  busy_d       = 1'b0;
               end else begin
                  res_chan_d = ffs_idx;
               end
            end
         end
         default: ;
      endcase
      // A late frame sync is dropped but flagged; setting beats clearing.
      if (fs && state_q != IDLE) overrun_d = 1'b1;
      else if (ovr_clr)          overrun_d = 1'b0;
      else                       overrun_d = overrun;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q       <= '0;
         res_chan   <= '0;
         res_start  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         done_cnt   <= '0;
         overrun    <= 1'b0;
         wdog_err   <= 1'b0;
      end else begin
         en_q       <= en_d;
         res_chan   <= res_chan_d;
         res_start  <= res_start_d;
         busy       <= busy_d;
         frame_done <= frame_done_d;
         done_cnt   <= done_cnt_d;
         overrun    <= overrun_d;
         wdog_err   <= wdog_err_d;
      end
   end

endmodule
